// File: rtl/tfc_pkg.sv
// Shared constants and helpers for the TFC distribution path.
// Default word and line geometry, plus the log2 helper used for pointer and delay widths.
package tfc_pkg;

    localparam int TFC_WIDTH    = 8;
    localparam int TFC_DEPTH    = 256;
    localparam int TFC_CHANNELS = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/tfc_delay_tap.sv
// One channel's read tap on the shared circular buffer: delay register, read address,
// zero-delay bypass, history/validity gate and the registered output.
module tfc_delay_tap
    import tfc_pkg::*;
#(
    parameter int WIDTH = TFC_WIDTH,
    parameter int DEPTH = TFC_DEPTH,
    parameter int DLY_W = clog2(DEPTH),
    parameter int PTR_W = clog2(DEPTH),
    parameter int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DLY_W-1:0] delay_cfg,
    input  logic [PTR_W-1:0] wptr,
    input  logic [CNT_W-1:0] wcnt,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] rdata,
    output logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] tfc_out,
    output logic             out_valid
);

    logic [DLY_W-1:0] delay_q, delay_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] tap_word;

    // Unsigned wrap: at D = DEPTH-1 this lands on wptr+1, the oldest entry.
    assign raddr = wptr - PTR_W'(delay_q);

    always_comb begin
        delay_d  = delay_cfg;
        out_d    = out_q;
        valid_d  = valid_q;
        tap_word = (delay_q == '0) ? wdata : rdata;
        if (en) begin
            if (wcnt >= CNT_W'(delay_q)) begin
                out_d   = tap_word;
                valid_d = 1'b1;
            end else begin
                out_d   = '0;
                valid_d = 1'b0;
            end
        end
    end

    // The delay tracks its config through reset too, so the first post-reset
    // edge already gates on the programmed delay rather than on zero.
    always_ff @(posedge clk) begin
        delay_q <= delay_d;
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign tfc_out   = out_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/tfc_delay_line.sv
// Multi-channel programmable TFC delay line: one shared circular buffer and write
// pointer, with an independent read tap per channel.
module tfc_delay_line
    import tfc_pkg::*;
#(
    parameter int WIDTH    = TFC_WIDTH,
    parameter int DEPTH    = TFC_DEPTH,
    parameter int CHANNELS = TFC_CHANNELS,
    parameter int DLY_W    = clog2(DEPTH)
) (
    input  logic                      main_clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS*WIDTH-1:0] tfc_in,
    input  logic [CHANNELS*DLY_W-1:0] delay_cfg,
    output logic [CHANNELS*WIDTH-1:0] tfc_out,
    output logic [CHANNELS-1:0]       out_valid
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CHANNELS*WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]          wptr_q, wptr_d;
    logic [CNT_W-1:0]          wcnt_q, wcnt_d;

    always_comb begin
        wptr_d = wptr_q;
        wcnt_d = wcnt_q;
        if (en) begin
            wptr_d = wptr_q + PTR_W'(1);
            if (wcnt_q != CNT_W'(DEPTH)) wcnt_d = wcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge main_clk) begin
        if (rst) begin
            wptr_q <= '0;
            wcnt_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            wcnt_q <= wcnt_d;
        end
    end

    // Array contents are never cleared; the taps' history gate hides stale slots.
    always_ff @(posedge main_clk) begin
        if (en && !rst) mem_q[wptr_q] <= tfc_in;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_tap
        logic [PTR_W-1:0] raddr;
        logic [WIDTH-1:0] rdata;

        assign rdata = mem_q[raddr][c*WIDTH +: WIDTH];

        tfc_delay_tap #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .DLY_W (DLY_W),
            .PTR_W (PTR_W),
            .CNT_W (CNT_W)
        ) u_tap (
            .clk       (main_clk),
            .rst       (rst),
            .en        (en),
            .delay_cfg (delay_cfg[c*DLY_W +: DLY_W]),
            .wptr      (wptr_q),
            .wcnt      (wcnt_q),
            .wdata     (tfc_in[c*WIDTH +: WIDTH]),
            .rdata     (rdata),
            .raddr     (raddr),
            .tfc_out   (tfc_out[c*WIDTH +: WIDTH]),
            .out_valid (out_valid[c])
        );
    end

endmodule
